// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD endpoint: receives 48-bit command frames, checks
// framing and CRC7, and serialises a locally supplied 48-bit response.
module sd_cmd_responder #(
    parameter int unsigned NCR_CYCLES = 2
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_sd_clk,
    input  logic        i_sd_cmd,
    output logic        o_sd_cmd,
    output logic        o_sd_cmd_oe,
    output logic        o_cmd_valid,
    output logic [5:0]  o_cmd_index,
    output logic [31:0] o_cmd_arg,
    output logic        o_cmd_crc_ok,
    input  logic        i_cmd_ack,
    input  logic        i_rsp_valid,
    input  logic        i_rsp_skip,
    input  logic [5:0]  i_rsp_index,
    input  logic [31:0] i_rsp_arg,
    output logic        o_busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RX    = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_TX    = 3'd5;

    localparam logic [6:0] NCR_MAX = 7'(NCR_CYCLES);

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        crc7_step = {c[5:0], 1'b0} ^ ({7{c[6] ^ b}} & 7'h09);
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            c = crc7_step(c, d[i]);
        end
        return c;
    endfunction

    logic        sclk_s1_q, sclk_s2_q, sclk_prev_q;
    logic        cmd_s1_q, cmd_s2_q;
    logic        rise, fall;

    logic [2:0]  state_q, state_d;
    logic [47:0] rx_sr_q, rx_sr_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  crc_q, crc_d;
    logic [6:0]  ncr_q, ncr_d;
    logic [47:0] tx_sr_q, tx_sr_d;
    logic [5:0]  tx_cnt_q, tx_cnt_d;
    logic        sd_cmd_q, sd_cmd_d;
    logic        sd_oe_q, sd_oe_d;
    logic        valid_q, valid_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d;
    logic        crc_ok_q, crc_ok_d;
    logic [39:0] rsp_head;

    assign rise     = sclk_s2_q & ~sclk_prev_q;
    assign fall     = ~sclk_s2_q & sclk_prev_q;
    assign rsp_head = {2'b00, i_rsp_index, i_rsp_arg};

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            cmd_s1_q    <= 1'b1;
            cmd_s2_q    <= 1'b1;
        end else begin
            sclk_s1_q   <= i_sd_clk;
            sclk_s2_q   <= sclk_s1_q;
            sclk_prev_q <= sclk_s2_q;
            cmd_s1_q    <= i_sd_cmd;
            cmd_s2_q    <= cmd_s1_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        rx_sr_d   = rx_sr_q;
        bit_cnt_d = bit_cnt_q;
        crc_d     = crc_q;
        ncr_d     = ncr_q;
        tx_sr_d   = tx_sr_q;
        tx_cnt_d  = tx_cnt_q;
        sd_cmd_d  = sd_cmd_q;
        sd_oe_d   = sd_oe_q;
        valid_d   = valid_q;
        idx_d     = idx_q;
        arg_d     = arg_q;
        crc_ok_d  = crc_ok_q;

        if (rise && ncr_q != NCR_MAX) begin
            ncr_d = ncr_q + 7'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (rise && !cmd_s2_q) begin
                    rx_sr_d   = '0;
                    bit_cnt_d = 6'd1;
                    crc_d     = '0;
                    state_d   = S_RX;
                end
            end
            S_RX: begin
                if (rise) begin
                    rx_sr_d   = {rx_sr_q[46:0], cmd_s2_q};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q < 6'd40) begin
                        crc_d = crc7_step(crc_q, cmd_s2_q);
                    end
                    if (bit_cnt_q == 6'd47) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                ncr_d     = '0;
                bit_cnt_d = '0;
                // A frame needs start 0, transmission 1 and end 1
                if (!rx_sr_q[47] && rx_sr_q[46] && rx_sr_q[0]) begin
                    idx_d    = rx_sr_q[45:40];
                    arg_d    = rx_sr_q[39:8];
                    crc_ok_d = (crc_q == rx_sr_q[7:1]);
                    valid_d  = 1'b1;
                    state_d  = S_HOLD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (i_cmd_ack) begin
                    valid_d = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_rsp_valid) begin
                    tx_sr_d  = {rsp_head, crc7_40(rsp_head), 1'b1};
                    tx_cnt_d = '0;
                    state_d  = S_TX;
                end else if (i_rsp_skip) begin
                    state_d = S_IDLE;
                end
            end
            S_TX: begin
                if (fall) begin
                    if (!sd_oe_q) begin
                        if (ncr_q == NCR_MAX) begin
                            sd_oe_d  = 1'b1;
                            sd_cmd_d = tx_sr_q[47];
                            tx_sr_d  = {tx_sr_q[46:0], 1'b0};
                            tx_cnt_d = 6'd1;
                        end
                    end else if (tx_cnt_q == 6'd48) begin
                        sd_oe_d  = 1'b0;
                        sd_cmd_d = 1'b1;
                        tx_cnt_d = '0;
                        state_d  = S_IDLE;
                    end else begin
                        sd_cmd_d = tx_sr_q[47];
                        tx_sr_d  = {tx_sr_q[46:0], 1'b0};
                        tx_cnt_d = tx_cnt_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            rx_sr_q   <= '0;
            bit_cnt_q <= '0;
            crc_q     <= '0;
            ncr_q     <= '0;
            tx_sr_q   <= '0;
            tx_cnt_q  <= '0;
            sd_cmd_q  <= 1'b1;
            sd_oe_q   <= 1'b0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            arg_q     <= '0;
            crc_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_sr_q   <= rx_sr_d;
            bit_cnt_q <= bit_cnt_d;
            crc_q     <= crc_d;
            ncr_q     <= ncr_d;
            tx_sr_q   <= tx_sr_d;
            tx_cnt_q  <= tx_cnt_d;
            sd_cmd_q  <= sd_cmd_d;
            sd_oe_q   <= sd_oe_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            arg_q     <= arg_d;
            crc_ok_q  <= crc_ok_d;
        end
    end

    assign o_sd_cmd     = sd_cmd_q;
    assign o_sd_cmd_oe  = sd_oe_q;
    assign o_cmd_valid  = valid_q;
    assign o_cmd_index  = idx_q;
    assign o_cmd_arg    = arg_q;
    assign o_cmd_crc_ok = crc_ok_q;
    assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Bench for sd_cmd_responder: two instances (NCR 2 and 8) share one host,
// fixed and random command frames checked against a CRC7 division model.
module tb_sd_cmd_responder;

    localparam int LOGN = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sd_clk = 1'b0;
    logic        host_cmd = 1'b1;
    logic        ack = 1'b0;
    logic        rsp_valid = 1'b0;
    logic        rsp_skip = 1'b0;
    logic [5:0]  rsp_idx = '0;
    logic [31:0] rsp_arg = '0;

    logic [1:0]  sd_in, sd_out, sd_oe, cv, cok, busy;
    logic [5:0]  cidx [2];
    logic [31:0] carg [2];

    logic        oe_log  [2][LOGN];
    logic        bit_log [2][LOGN];
    int          rise_n = 0;
    int          n_chk = 0;
    int          n_err = 0;

    assign sd_in[0] = sd_oe[0] ? sd_out[0] : host_cmd;
    assign sd_in[1] = sd_oe[1] ? sd_out[1] : host_cmd;

    sd_cmd_responder #(.NCR_CYCLES(2)) u_dut2 (
        .i_clock(clk), .i_reset_n(rst_n), .i_sd_clk(sd_clk),
        .i_sd_cmd(sd_in[0]), .o_sd_cmd(sd_out[0]), .o_sd_cmd_oe(sd_oe[0]),
        .o_cmd_valid(cv[0]), .o_cmd_index(cidx[0]), .o_cmd_arg(carg[0]),
        .o_cmd_crc_ok(cok[0]), .i_cmd_ack(ack), .i_rsp_valid(rsp_valid),
        .i_rsp_skip(rsp_skip), .i_rsp_index(rsp_idx), .i_rsp_arg(rsp_arg),
        .o_busy(busy[0])
    );

    sd_cmd_responder #(.NCR_CYCLES(8)) u_dut8 (
        .i_clock(clk), .i_reset_n(rst_n), .i_sd_clk(sd_clk),
        .i_sd_cmd(sd_in[1]), .o_sd_cmd(sd_out[1]), .o_sd_cmd_oe(sd_oe[1]),
        .o_cmd_valid(cv[1]), .o_cmd_index(cidx[1]), .o_cmd_arg(carg[1]),
        .o_cmd_crc_ok(cok[1]), .i_cmd_ack(ack), .i_rsp_valid(rsp_valid),
        .i_rsp_skip(rsp_skip), .i_rsp_index(rsp_idx), .i_rsp_arg(rsp_arg),
        .o_busy(busy[1])
    );

    always #5 clk = ~clk;

    initial begin
        #2;
        forever #40 sd_clk = ~sd_clk;
    end

    always @(posedge sd_clk) begin
        oe_log[0][rise_n % LOGN]  <= sd_oe[0];
        oe_log[1][rise_n % LOGN]  <= sd_oe[1];
        bit_log[0][rise_n % LOGN] <= sd_out[0];
        bit_log[1][rise_n % LOGN] <= sd_out[1];
        rise_n <= rise_n + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // CRC7 as polynomial long division of m * x^7 by x^7+x^3+1
    function automatic logic [6:0] crc7_ref(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    task automatic send_frame(input logic [47:0] f, output int e);
        for (int i = 47; i >= 0; i--) begin
            @(negedge sd_clk);
            host_cmd = f[i];
        end
        @(posedge sd_clk);
        e = rise_n;
        @(negedge sd_clk);
        host_cmd = 1'b1;
    endtask

    task automatic check_quiet(input int e);
        int cnt;
        while (rise_n <= e + 62) @(posedge sd_clk);
        for (int d = 0; d < 2; d++) begin
            cnt = 0;
            for (int k = 1; k <= 60; k++) cnt += int'(oe_log[d][(e + k) % LOGN]);
            check($sformatf("quiet%0d", d), cnt, 0);
        end
    endtask

    task automatic check_rsp(input int e, input logic [47:0] rf);
        int n, first, oec;
        logic [47:0] got;
        while (rise_n <= e + 62) @(posedge sd_clk);
        for (int d = 0; d < 2; d++) begin
            n = (d == 0) ? 2 : 8;
            first = 0;
            for (int k = 1; k <= 30; k++) begin
                if (first == 0 && oe_log[d][(e + k) % LOGN]) first = k;
            end
            check($sformatf("ncr%0d", d), first, n + 1);
            got = '0;
            oec = 0;
            for (int b = 0; b < 48; b++) begin
                got = {got[46:0], bit_log[d][(e + n + 1 + b) % LOGN]};
                oec += int'(oe_log[d][(e + n + 1 + b) % LOGN]);
            end
            check($sformatf("rsp_oe%0d", d), oec, 48);
            check($sformatf("rsp_frame%0d", d), got, rf);
            check($sformatf("rsp_rel%0d", d), oe_log[d][(e + n + 49) % LOGN], 0);
        end
    endtask

    task automatic do_cmd(input logic [47:0] f, input bit rsp,
                          input logic [5:0] ri, input logic [31:0] ra,
                          input int ack_dly, input bit chk_tx, output int e);
        logic fr_ok, ok_exp;
        logic [47:0] rf;
        int c;
        fr_ok  = f[46] & f[0];
        ok_exp = (crc7_ref(f[47:8]) == f[7:1]);
        send_frame(f, e);
        c = 0;
        while (cv == 2'b00 && c < 20) begin
            @(negedge clk);
            c++;
        end
        for (int d = 0; d < 2; d++) check($sformatf("valid%0d", d), cv[d], fr_ok);
        if (!fr_ok) begin
            check("drop_busy", busy, 2'b00);
            check_quiet(e);
            return;
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("idx%0d", d), cidx[d], f[45:40]);
            check($sformatf("arg%0d", d), carg[d], f[39:8]);
            check($sformatf("crc_ok%0d", d), cok[d], ok_exp);
        end
        repeat (ack_dly) begin
            @(negedge clk);
            check("hold", cv, 2'b11);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("ack_drop", cv, 2'b00);
        if (rsp) begin
            rsp_idx   = ri;
            rsp_arg   = ra;
            rsp_valid = 1'b1;
            rsp_skip  = 1'($urandom_range(0, 1));
            @(negedge clk);
            rsp_valid = 1'b0;
            rsp_skip  = 1'b0;
            rf = {2'b00, ri, ra, crc7_ref({2'b00, ri, ra}), 1'b1};
            if (chk_tx) check_rsp(e, rf);
        end else begin
            rsp_skip = 1'b1;
            @(negedge clk);
            rsp_skip = 1'b0;
            @(negedge clk);
            check("skip_idle", busy, 2'b00);
            check_quiet(e);
        end
    endtask

    initial begin
        int e, kind, p;
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [47:0] f;

        #1 rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_oe", sd_oe, 2'b00);
        check("rst_cmd", sd_out, 2'b11);
        check("rst_valid", cv, 2'b00);
        check("rst_busy", busy, 2'b00);
        check("rst_crcok", cok, 2'b00);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_idx%0d", d), cidx[d], 0);
            check($sformatf("rst_arg%0d", d), carg[d], 0);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        do_cmd(48'h40_00000000_95, 0, 6'd0, 32'd0, 10, 1, e);
        do_cmd(48'h48_000001AA_87, 1, 6'd8, 32'h1AA, 1, 1, e);
        do_cmd(48'h40_00000000_97, 0, 6'd0, 32'd0, 2, 1, e);
        do_cmd(48'h40_00000000_94, 0, 6'd0, 32'd0, 0, 1, e);
        do_cmd(48'h40_00000000_95, 1, 6'h3F, 32'hFFFF_FFFF, 0, 1, e);

        do_cmd(48'h48_000001AA_87, 1, 6'd8, 32'h1AA, 0, 0, e);
        while (rise_n < e + 23) @(posedge sd_clk);
        check("pre_rst_oe", sd_oe, 2'b11);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_oe", sd_oe, 2'b00);
        check("mid_rst_cmd", sd_out, 2'b11);
        check("mid_rst_busy", busy, 2'b00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        do_cmd(48'h40_00000000_95, 0, 6'd0, 32'd0, 1, 1, e);

        for (int t = 0; t < 14; t++) begin
            idx = 6'($urandom_range(0, 63));
            arg = $urandom;
            f = {2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1};
            kind = $urandom_range(0, 3);
            if (kind == 1) begin
                p = 1 + $urandom_range(0, 6);
                f[p] = ~f[p];
            end else if (kind == 2) begin
                f[0] = 1'b0;
            end else if (kind == 3) begin
                f[46] = 1'b0;
            end
            do_cmd(f, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                   $urandom, $urandom_range(0, 3), 1, e);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sd_cmd_responder.md
Name: sd_cmd_responder

Overview:
- Card-side endpoint of the SD CMD line, the counterpart of the host-side bit-banged SD pin port.
- Receives 48-bit command frames from the host, checks framing and CRC7, and presents each command to local card logic.
- Serialises a 48-bit response frame supplied by local logic back onto CMD.
- Used in the SD emulation/loopback path and as a synthesizable bench target for the host driver.

Parameters:
NCR_CYCLES, 2, minimum number of SD_CLK rising edges between the command end bit and the response start bit (legal range 2..64).

Ports:
i_clock  in  1  system clock; must be at least 4x SD_CLK.
i_reset_n  in  1  asynchronous active-low reset.
i_sd_clk  in  1  SD_CLK from host; asynchronous to i_clock.
i_sd_cmd  in  1  CMD line input; asynchronous.
o_sd_cmd  out  1  CMD drive value.
o_sd_cmd_oe  out  1  CMD output enable; 0 means released (pull-up holds CMD at 1).
o_cmd_valid  out  1  received command available.
o_cmd_index  out  6  command index.
o_cmd_arg  out  32  command argument.
o_cmd_crc_ok  out  1  received CRC7 matched.
i_cmd_ack  in  1  local logic consumed the command.
i_rsp_valid  in  1  response fields valid; start transmission.
i_rsp_skip  in  1  send no response; return to idle.
i_rsp_index  in  6  response index field.
i_rsp_arg  in  32  response 32-bit payload.
o_busy  out  1  high in every state except IDLE.

Behaviour:
- Synchronisation:
  - i_sd_clk and i_sd_cmd each pass through a 2-FF synchroniser.
  - Rise and fall pulses on SD_CLK come from the synchronised value and its previous value.
  - CMD is sampled on rise pulses. o_sd_cmd and o_sd_cmd_oe change only on fall pulses, except on reset.
- Reset values:
  - o_sd_cmd=1, o_sd_cmd_oe=0, o_cmd_valid=0, o_cmd_index=0, o_cmd_arg=0, o_cmd_crc_ok=0, o_busy=0.
  - State is IDLE and all counters are 0.
- Reset mid-operation: asserting i_reset_n low releases CMD immediately (asynchronous). Any partial frame is discarded.
- IDLE:
  - Wait for a rise pulse with CMD=0 (start bit).
  - Load a 48-bit shift register with the start bit, set the bit counter to 1, go to RX.
- RX:
  - On each rise pulse, shift in CMD and increment the bit counter. At count 48, go to CHECK.
  - CRC7 (polynomial x^7+x^3+1, initial value 0) is accumulated serially over bits 47..8.
- CHECK (one i_clock cycle):
  - Framing is bit46 (transmission bit)=1 and bit0 (end bit)=1.
  - Framing fails: discard the frame silently and return to IDLE.
  - Framing passes:
    - Latch o_cmd_index=bits[45:40], o_cmd_arg=bits[39:8].
    - Set o_cmd_crc_ok=(computed CRC==bits[7:1]).
    - Assert o_cmd_valid, clear the NCR counter, go to HOLD.
  - A CRC mismatch is still presented, so local logic can flag COM_CRC_ERROR.
- HOLD:
  - o_cmd_valid stays high until i_cmd_ack=1. In the ack cycle o_cmd_valid drops and the state goes to WAIT_RSP.
  - The NCR counter counts rise pulses from CHECK onwards, saturating at NCR_CYCLES.
- WAIT_RSP:
  - i_rsp_skip=1: go to IDLE.
  - i_rsp_valid=1: latch the response frame = {0, 0, i_rsp_index, i_rsp_arg, crc7(first 40 bits), 1}, go to TX.
  - If both are high in the same cycle, i_rsp_valid wins.
  - Input commands are ignored while not in IDLE/RX.
- TX:
  - Transmission begins on the first fall pulse at which the NCR counter equals NCR_CYCLES. Until then CMD stays released.
  - On that fall pulse: o_sd_cmd_oe=1, o_sd_cmd=frame bit 47.
  - On each later fall pulse, output the next bit.
  - On the fall pulse after bit 0 has been driven for one full SD_CLK period, set o_sd_cmd_oe=0 and o_sd_cmd=1, then go to IDLE.
- CRC: one shared serial CRC7 function serves both directions; response CRC is computed combinationally over the latched 40 bits.
- Back-to-back commands: a start bit seen in IDLE is accepted on the very first rise pulse after returning to IDLE.

Test Plan:
- CMD0 frame 0x40_00000000_95 clocked MSB-first at i_clock/8 -> o_cmd_valid=1, index=0, arg=0x00000000, crc_ok=1; valid holds until i_cmd_ack.
- CMD8 frame 0x48_000001AA_87 -> index=8, arg=0x000001AA, crc_ok=1. Then i_rsp_valid with index=8, arg=0x000001AA -> CMD is released for exactly 2 rise edges after the end bit, then 48 bits 0x08_000001AA_{crc7,1} appear on falling edges, with the CRC matching the bench CRC7 model; oe drops after the end bit.
- CMD0 with last byte 0x97 -> o_cmd_valid=1, crc_ok=0. Then i_rsp_skip -> CMD never driven, o_busy=0 within 2 i_clock cycles.
- CMD0 with end bit 0 (last byte 0x94) -> o_cmd_valid stays 0, state returns to IDLE; a following valid CMD0 is accepted.
- Reset asserted at response bit 20 -> o_sd_cmd_oe=0 and o_sd_cmd=1 immediately, with no i_clock edge required. After release, a new CMD0 decodes correctly.
- NCR_CYCLES=8 with i_rsp_valid asserted immediately after ack -> start bit appears on the fall following the 8th rise after the end bit.
